// File: rtl/usb_consts_pkg.sv
// usb_consts_pkg: USB packet identifier and PID-type encodings shared by the protocol engines
package usb_consts_pkg;

    typedef enum logic [1:0] {
        UsbPidTypeSpecial   = 2'b00,
        UsbPidTypeToken     = 2'b01,
        UsbPidTypeHandshake = 2'b10,
        UsbPidTypeData      = 2'b11
    } usb_pid_type_e;

    typedef enum logic [3:0] {
        UsbPidOut   = 4'b0001,
        UsbPidIn    = 4'b1001,
        UsbPidSof   = 4'b0101,
        UsbPidSetup = 4'b1101,
        UsbPidData0 = 4'b0011,
        UsbPidData1 = 4'b1011,
        UsbPidAck   = 4'b0010,
        UsbPidNak   = 4'b1010,
        UsbPidStall = 4'b1110
    } usb_pid_e;

endpackage

// File: rtl/usb_fs_nb_out_pe.sv
// usb_fs_nb_out_pe: device-side full-speed OUT/SETUP protocol engine streaming payload to the endpoint buffers
module usb_fs_nb_out_pe
    import usb_consts_pkg::*;
#(
    parameter int unsigned NumOutEps         = 12,
    parameter int unsigned MaxOutPktSizeByte = 64,
    parameter int unsigned DataStartTimeout  = 73,
    localparam int unsigned OutEpW   = $clog2(NumOutEps),
    localparam int unsigned PktW     = $clog2(MaxOutPktSizeByte),
    localparam int unsigned TimeoutW = $clog2(DataStartTimeout)
) (
    input  logic                 clk_48mhz_i,
    input  logic                 rst_ni,
    input  logic                 link_reset_i,
    input  logic                 link_active_i,
    input  logic [6:0]           dev_addr_i,
    input  logic                 rx_pkt_start_i,
    input  logic                 rx_pkt_end_i,
    input  logic                 rx_pkt_valid_i,
    input  logic [3:0]           rx_pid_i,
    input  logic [6:0]           rx_addr_i,
    input  logic [3:0]           rx_endp_i,
    input  logic                 rx_data_put_i,
    input  logic [7:0]           rx_data_i,
    output logic                 tx_pkt_start_o,
    output logic [3:0]           tx_pid_o,
    input  logic                 tx_pkt_end_i,
    output logic [3:0]           out_ep_current_o,
    output logic                 out_ep_newpkt_o,
    output logic                 out_ep_setup_o,
    output logic                 out_ep_data_put_o,
    output logic [PktW-1:0]      out_ep_put_addr_o,
    output logic [7:0]           out_ep_data_o,
    output logic                 out_ep_acked_o,
    output logic                 out_ep_rollback_o,
    input  logic [NumOutEps-1:0] out_ep_enabled_i,
    input  logic [NumOutEps-1:0] out_ep_control_i,
    input  logic [NumOutEps-1:0] out_ep_full_i,
    input  logic [NumOutEps-1:0] out_ep_stall_i,
    input  logic [NumOutEps-1:0] out_ep_iso_i,
    output logic [NumOutEps-1:0] out_data_toggle_o,
    input  logic                 out_datatog_we_i,
    input  logic [NumOutEps-1:0] out_datatog_status_i,
    input  logic [NumOutEps-1:0] out_datatog_mask_i,
    output logic                 event_nak_out_o,
    output logic                 event_drop_out_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRcvdOut,
        StRcvdDataStart,
        StRcvdDataEnd
    } state_e;

    state_e state_q, state_d;

    logic [TimeoutW-1:0]  timeout_q;
    logic [PktW:0]        byte_cnt_q;
    logic                 too_long_q;
    logic                 pkt_valid_q;
    logic [3:0]           pid_q;
    logic [NumOutEps-1:0] tog_hw, tog_d;
    logic [3:0]           cur_d;
    logic                 setup_d, newpkt_d;
    logic                 tx_start, ack_d, rb_d, nak_d, drop_d;
    logic [3:0]           tx_pid;
    logic                 unused_tx_pkt_end;

    // The handshake is fire-and-forget, so its completion strobe carries no information here.
    assign unused_tx_pkt_end = tx_pkt_end_i;

    logic [OutEpW-1:0] ep_idx, cur_idx;
    logic              ep_active, token_ok, out_tok, setup_tok, data_pid_ok;

    assign ep_idx      = rx_endp_i[OutEpW-1:0];
    assign cur_idx     = out_ep_current_o[OutEpW-1:0];
    assign ep_active   = (32'(rx_endp_i) < NumOutEps) && out_ep_enabled_i[ep_idx];
    assign token_ok    = rx_pkt_end_i && rx_pkt_valid_i && (rx_pid_i[1:0] == UsbPidTypeToken) &&
                         (rx_addr_i == dev_addr_i) && ep_active;
    assign out_tok     = token_ok && (rx_pid_i == UsbPidOut);
    assign setup_tok   = token_ok && (rx_pid_i == UsbPidSetup) && out_ep_control_i[ep_idx];
    assign data_pid_ok = (pid_q == UsbPidData0) || (pid_q == UsbPidData1);

    assign tx_pkt_start_o = tx_start;
    assign tx_pid_o       = tx_pid;

    // Next state, handshake choice and hardware toggle update for the current transaction.
    always_comb begin
        state_d  = state_q;
        cur_d    = out_ep_current_o;
        setup_d  = out_ep_setup_o;
        newpkt_d = 1'b0;
        tx_start = 1'b0;
        tx_pid   = 4'b0000;
        ack_d    = 1'b0;
        rb_d     = 1'b0;
        nak_d    = 1'b0;
        drop_d   = 1'b0;
        tog_hw   = out_data_toggle_o;
        case (state_q)
            StIdle: begin
                if (out_tok || setup_tok) begin
                    state_d  = StRcvdOut;
                    cur_d    = rx_endp_i;
                    setup_d  = setup_tok;
                    newpkt_d = 1'b1;
                    if (setup_tok) tog_hw[ep_idx] = 1'b0;
                end
            end
            StRcvdOut: begin
                if (rx_pkt_start_i) begin
                    state_d = StRcvdDataStart;
                end else if (timeout_q == '0) begin
                    state_d = StIdle;
                    rb_d    = 1'b1;
                    drop_d  = 1'b1;
                end
            end
            StRcvdDataStart: begin
                if (rx_pkt_end_i) state_d = StRcvdDataEnd;
            end
            StRcvdDataEnd: begin
                state_d = StIdle;
                if (!pkt_valid_q || !data_pid_ok || too_long_q) begin
                    rb_d   = 1'b1;
                    drop_d = 1'b1;
                end else if (out_ep_iso_i[cur_idx]) begin
                    ack_d  = !out_ep_full_i[cur_idx];
                    rb_d   = out_ep_full_i[cur_idx];
                    drop_d = out_ep_full_i[cur_idx];
                end else if (out_ep_setup_o) begin
                    if (!out_ep_full_i[cur_idx]) begin
                        tx_start        = 1'b1;
                        tx_pid          = UsbPidAck;
                        ack_d           = 1'b1;
                        tog_hw[cur_idx] = 1'b1;
                    end else begin
                        rb_d   = 1'b1;
                        drop_d = 1'b1;
                    end
                end else if (out_ep_stall_i[cur_idx]) begin
                    tx_start = 1'b1;
                    tx_pid   = UsbPidStall;
                    rb_d     = 1'b1;
                end else if (out_ep_full_i[cur_idx]) begin
                    tx_start = 1'b1;
                    tx_pid   = UsbPidNak;
                    rb_d     = 1'b1;
                    nak_d    = 1'b1;
                end else if (pid_q[3] != out_data_toggle_o[cur_idx]) begin
                    tx_start = 1'b1;
                    tx_pid   = UsbPidAck;
                    rb_d     = 1'b1;
                end else begin
                    tx_start        = 1'b1;
                    tx_pid          = UsbPidAck;
                    ack_d           = 1'b1;
                    tog_hw[cur_idx] = !out_data_toggle_o[cur_idx];
                end
            end
            default: state_d = StIdle;
        endcase
        if (link_reset_i || !link_active_i) begin
            state_d  = StIdle;
            newpkt_d = 1'b0;
            tx_start = 1'b0;
            tx_pid   = 4'b0000;
            ack_d    = 1'b0;
            nak_d    = 1'b0;
            drop_d   = 1'b0;
            rb_d     = (state_q != StIdle);
            if (link_reset_i) tog_hw = '0;
        end
        tog_d = out_datatog_we_i ? ((tog_hw & ~out_datatog_mask_i) | (out_datatog_status_i & out_datatog_mask_i))
                                 : tog_hw;
    end

    // State, transaction context, toggles and single-cycle event pulses.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= StIdle;
            out_ep_current_o  <= '0;
            out_ep_setup_o    <= 1'b0;
            out_ep_newpkt_o   <= 1'b0;
            out_data_toggle_o <= '0;
            out_ep_acked_o    <= 1'b0;
            out_ep_rollback_o <= 1'b0;
            event_nak_out_o   <= 1'b0;
            event_drop_out_o  <= 1'b0;
        end else begin
            state_q           <= state_d;
            out_ep_current_o  <= cur_d;
            out_ep_setup_o    <= setup_d;
            out_ep_newpkt_o   <= newpkt_d;
            out_data_toggle_o <= tog_d;
            out_ep_acked_o    <= ack_d;
            out_ep_rollback_o <= rb_d;
            event_nak_out_o   <= nak_d;
            event_drop_out_o  <= drop_d;
        end
    end

    // Data-start timeout, payload byte forwarding and received-packet status capture.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q         <= TimeoutW'(DataStartTimeout);
            byte_cnt_q        <= '0;
            too_long_q        <= 1'b0;
            pkt_valid_q       <= 1'b0;
            pid_q             <= 4'b0000;
            out_ep_data_put_o <= 1'b0;
            out_ep_put_addr_o <= '0;
            out_ep_data_o     <= '0;
        end else begin
            timeout_q         <= (state_q == StRcvdOut) ? timeout_q - TimeoutW'(1) : TimeoutW'(DataStartTimeout);
            out_ep_data_put_o <= 1'b0;
            if (state_q == StIdle) begin
                byte_cnt_q        <= '0;
                too_long_q        <= 1'b0;
                out_ep_put_addr_o <= '0;
            end
            if (state_q == StRcvdDataStart && rx_data_put_i) begin
                if (byte_cnt_q[PktW]) begin
                    too_long_q <= 1'b1;
                end else begin
                    out_ep_data_put_o <= 1'b1;
                    out_ep_put_addr_o <= byte_cnt_q[PktW-1:0];
                    out_ep_data_o     <= rx_data_i;
                    byte_cnt_q        <= byte_cnt_q + (PktW+1)'(1);
                end
            end
            if (state_q == StRcvdDataStart && rx_pkt_end_i) begin
                pkt_valid_q <= rx_pkt_valid_i;
                pid_q       <= rx_pid_i;
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_nb_out_pe.sv
// tb_usb_fs_nb_out_pe: randomized transaction-level check of the OUT/SETUP protocol engine
module tb_usb_fs_nb_out_pe;
    import usb_consts_pkg::*;

    localparam int NEps = 12;
    localparam logic [6:0] DevAddr = 7'h2a;

    logic clk_48mhz_i = 1'b0;
    logic rst_ni = 1'b0;
    logic link_reset_i = 1'b0, link_active_i = 1'b1;
    logic [6:0] dev_addr_i = DevAddr;
    logic rx_pkt_start_i = 1'b0, rx_pkt_end_i = 1'b0, rx_pkt_valid_i = 1'b0;
    logic [3:0] rx_pid_i = '0, rx_endp_i = '0;
    logic [6:0] rx_addr_i = '0;
    logic rx_data_put_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic tx_pkt_start_o, tx_pkt_end_i = 1'b0;
    logic [3:0] tx_pid_o, out_ep_current_o;
    logic out_ep_newpkt_o, out_ep_setup_o, out_ep_data_put_o, out_ep_acked_o, out_ep_rollback_o;
    logic [5:0] out_ep_put_addr_o;
    logic [7:0] out_ep_data_o;
    logic [NEps-1:0] en = '1, ctl = 12'h001, full = '0, stall = '0, iso = '0;
    logic [NEps-1:0] out_data_toggle_o;
    logic out_datatog_we_i = 1'b0;
    logic [NEps-1:0] out_datatog_status_i = '0, out_datatog_mask_i = '0;
    logic event_nak_out_o, event_drop_out_o;

    usb_fs_nb_out_pe dut (
        .clk_48mhz_i(clk_48mhz_i), .rst_ni(rst_ni), .link_reset_i(link_reset_i), .link_active_i(link_active_i),
        .dev_addr_i(dev_addr_i), .rx_pkt_start_i(rx_pkt_start_i), .rx_pkt_end_i(rx_pkt_end_i),
        .rx_pkt_valid_i(rx_pkt_valid_i), .rx_pid_i(rx_pid_i), .rx_addr_i(rx_addr_i), .rx_endp_i(rx_endp_i),
        .rx_data_put_i(rx_data_put_i), .rx_data_i(rx_data_i), .tx_pkt_start_o(tx_pkt_start_o),
        .tx_pid_o(tx_pid_o), .tx_pkt_end_i(tx_pkt_end_i), .out_ep_current_o(out_ep_current_o),
        .out_ep_newpkt_o(out_ep_newpkt_o), .out_ep_setup_o(out_ep_setup_o),
        .out_ep_data_put_o(out_ep_data_put_o), .out_ep_put_addr_o(out_ep_put_addr_o),
        .out_ep_data_o(out_ep_data_o), .out_ep_acked_o(out_ep_acked_o), .out_ep_rollback_o(out_ep_rollback_o),
        .out_ep_enabled_i(en), .out_ep_control_i(ctl), .out_ep_full_i(full), .out_ep_stall_i(stall),
        .out_ep_iso_i(iso), .out_data_toggle_o(out_data_toggle_o), .out_datatog_we_i(out_datatog_we_i),
        .out_datatog_status_i(out_datatog_status_i), .out_datatog_mask_i(out_datatog_mask_i),
        .event_nak_out_o(event_nak_out_o), .event_drop_out_o(event_drop_out_o)
    );

    always #5 clk_48mhz_i = ~clk_48mhz_i;

    int cyc = 0;
    always @(posedge clk_48mhz_i) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // event monitor, sampled on the falling edge
    int tx_n = 0, ack_n = 0, rb_n = 0, nak_n = 0, drop_n = 0, new_n = 0, put_n = 0;
    int tx_cyc = 0, rb_cyc = 0, drop_cyc = 0;
    logic [3:0] tx_pid_seen = '0;
    logic [5:0] pa [0:8191];
    logic [7:0] pd [0:8191];
    always @(negedge clk_48mhz_i) begin
        if (tx_pkt_start_o) begin tx_n++; tx_pid_seen = tx_pid_o; tx_cyc = cyc; end
        if (out_ep_acked_o) ack_n++;
        if (out_ep_rollback_o) begin rb_n++; rb_cyc = cyc; end
        if (event_nak_out_o) nak_n++;
        if (event_drop_out_o) begin drop_n++; drop_cyc = cyc; end
        if (out_ep_newpkt_o) new_n++;
        if (out_ep_data_put_o) begin pa[put_n % 8192] = out_ep_put_addr_o; pd[put_n % 8192] = out_ep_data_o; put_n++; end
    end

    logic [NEps-1:0] mtog = '0;
    logic [7:0] sent [0:127];
    int end_cyc = 0;

    task automatic step();
        @(posedge clk_48mhz_i); #1;
    endtask

    task automatic tok(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] ep);
        rx_pkt_start_i = 1'b1; step();
        rx_pkt_start_i = 1'b0; step();
        rx_pid_i = pid; rx_addr_i = a; rx_endp_i = ep; rx_pkt_valid_i = 1'b1; rx_pkt_end_i = 1'b1; end_cyc = cyc;
        step();
        rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    endtask

    task automatic dpkt(input logic [3:0] pid, input int n, input bit valid, input int intr);
        rx_pkt_start_i = 1'b1; step();
        rx_pkt_start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (intr != 0 && i == 4) begin
                rx_data_put_i = 1'b0;
                if (intr == 1) link_reset_i = 1'b1; else link_active_i = 1'b0;
                step();
                link_reset_i = 1'b0; link_active_i = 1'b1;
                break;
            end
            rx_data_put_i = 1'b1; rx_data_i = 8'($urandom); sent[i] = rx_data_i; step();
        end
        rx_data_put_i = 1'b0;
        rx_pid_i = pid; rx_pkt_valid_i = valid; rx_pkt_end_i = 1'b1; end_cyc = cyc;
        step();
        rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    endtask

    task automatic swtog(input logic [NEps-1:0] st, input logic [NEps-1:0] mk);
        out_datatog_we_i = 1'b1; out_datatog_status_i = st; out_datatog_mask_i = mk; step();
        out_datatog_we_i = 1'b0;
        mtog = (mtog & ~mk) | (st & mk);
        step();
        chk("sw_toggle", out_data_toggle_o, mtog);
    endtask

    // One token + data transaction; expectations come from the handshake rules applied to the config.
    task automatic txn(input logic [3:0] tpid, input logic [6:0] a, input logic [3:0] ep,
                       input logic [3:0] dpid, input int n, input bit valid, input int intr);
        int t0, a0, r0, k0, d0, w0, p0, e_ack, e_rb, e_nak, e_drop, e_puts, got_p, tend;
        logic [3:0] e_hs;
        bit accept, is_setup;
        t0 = tx_n; a0 = ack_n; r0 = rb_n; k0 = nak_n; d0 = drop_n; w0 = new_n; p0 = put_n;
        e_hs = 4'b0000; e_ack = 0; e_rb = 0; e_nak = 0; e_drop = 0; e_puts = 0;
        is_setup = (tpid == UsbPidSetup);
        accept = (a == DevAddr) && (ep < NEps) && en[ep] && (tpid == UsbPidOut || (is_setup && ctl[ep]));
        if (accept) begin
            if (is_setup) mtog[ep] = 1'b0;
            if (intr != 0) begin
                e_puts = 4; e_rb = 1;
            end else begin
                e_puts = (n > 64) ? 64 : n;
                if (!valid || !(dpid == UsbPidData0 || dpid == UsbPidData1) || n > 64) begin
                    e_rb = 1; e_drop = 1;
                end else if (iso[ep]) begin
                    if (!full[ep]) e_ack = 1; else begin e_rb = 1; e_drop = 1; end
                end else if (is_setup) begin
                    if (!full[ep]) begin e_hs = UsbPidAck; e_ack = 1; mtog[ep] = 1'b1; end
                    else begin e_rb = 1; e_drop = 1; end
                end else if (stall[ep]) begin
                    e_hs = UsbPidStall; e_rb = 1;
                end else if (full[ep]) begin
                    e_hs = UsbPidNak; e_rb = 1; e_nak = 1;
                end else if (dpid[3] != mtog[ep]) begin
                    e_hs = UsbPidAck; e_rb = 1;
                end else begin
                    e_hs = UsbPidAck; e_ack = 1; mtog[ep] = ~mtog[ep];
                end
            end
        end
        if (intr == 1) mtog = '0;
        tok(tpid, a, ep);
        step(); step();
        dpkt(dpid, n, valid, intr);
        tend = end_cyc;
        repeat (4) step();
        chk("handshake_count", tx_n - t0, (e_hs != 4'b0000) ? 1 : 0);
        if (e_hs != 4'b0000 && tx_n != t0) begin
            chk("handshake_pid", tx_pid_seen, e_hs);
            chk("handshake_delay", tx_cyc - tend, 1);
        end
        chk("acked", ack_n - a0, e_ack);
        chk("rollback", rb_n - r0, e_rb);
        chk("event_nak", nak_n - k0, e_nak);
        chk("event_drop", drop_n - d0, e_drop);
        chk("newpkt", new_n - w0, accept ? 1 : 0);
        got_p = put_n - p0;
        chk("put_count", got_p, e_puts);
        for (int i = 0; i < e_puts && i < got_p; i++) begin
            chk("put_addr", pa[(p0 + i) % 8192], i);
            chk("put_data", pd[(p0 + i) % 8192], sent[i]);
        end
        chk("toggles", out_data_toggle_o, mtog);
        if (accept) begin
            chk("current_ep", out_ep_current_o, ep);
            chk("setup_flag", out_ep_setup_o, is_setup);
        end
    endtask

    initial begin
        int r0, d0, t0, tend, n;
        logic [3:0] tp, dp, ep;
        #23;
        chk("rst_tx_start", tx_pkt_start_o, 0);
        chk("rst_tx_pid", tx_pid_o, 0);
        chk("rst_toggles", out_data_toggle_o, 0);
        chk("rst_outs", {out_ep_acked_o, out_ep_rollback_o, out_ep_data_put_o, out_ep_newpkt_o,
                         out_ep_setup_o, event_nak_out_o, event_drop_out_o}, 0);
        chk("rst_current", out_ep_current_o, 0);
        step(); rst_ni = 1'b1; step(); step();

        txn(UsbPidOut, DevAddr, 4'd1, UsbPidData0, 8, 1, 0);
        txn(UsbPidOut, DevAddr, 4'd1, UsbPidData0, 8, 1, 0);
        full[2] = 1'b1;
        txn(UsbPidOut, DevAddr, 4'd2, UsbPidData0, 8, 1, 0);
        full[2] = 1'b0; stall[2] = 1'b1;
        txn(UsbPidOut, DevAddr, 4'd2, UsbPidData0, 8, 1, 0);
        stall = 12'h005;
        txn(UsbPidSetup, DevAddr, 4'd0, UsbPidData0, 8, 1, 0);
        txn(UsbPidSetup, DevAddr, 4'd3, UsbPidData0, 8, 1, 0);
        stall = '0;

        r0 = rb_n; d0 = drop_n; t0 = tx_n;
        tok(UsbPidOut, DevAddr, 4'd4);
        tend = end_cyc;
        for (int i = 0; i < 120 && rb_n == r0; i++) step();
        chk("timeout_rollback", rb_n - r0, 1);
        chk("timeout_drop", drop_n - d0, 1);
        chk("timeout_delay", rb_cyc - tend, 75);
        chk("timeout_no_tx", tx_n - t0, 0);
        step(); step();

        txn(UsbPidOut, DevAddr, 4'd1, UsbPidData1, 8, 0, 0);
        txn(UsbPidOut, DevAddr, 4'd1, UsbPidData1, 65, 1, 0);
        txn(UsbPidOut, DevAddr, 4'd1, UsbPidData1, 64, 1, 0);
        txn(UsbPidOut, DevAddr, 4'd1, UsbPidAck, 3, 1, 0);
        iso[5] = 1'b1;
        txn(UsbPidOut, DevAddr, 4'd5, UsbPidData1, 4, 1, 0);
        full[5] = 1'b1;
        txn(UsbPidOut, DevAddr, 4'd5, UsbPidData0, 4, 1, 0);
        iso = '0; full = '0;
        swtog(12'hfff, 12'h0f0);
        txn(UsbPidOut, DevAddr, 4'd6, UsbPidData1, 10, 1, 2);
        txn(UsbPidOut, DevAddr, 4'd1, UsbPidData1, 10, 1, 1);
        txn(UsbPidOut, DevAddr, 4'd13, UsbPidData0, 4, 1, 0);
        txn(UsbPidOut, 7'h11, 4'd1, UsbPidData0, 4, 1, 0);

        for (int it = 0; it < 40; it++) begin
            en = 12'($urandom | $urandom); ctl = 12'($urandom); full = 12'($urandom & $urandom);
            stall = 12'($urandom & $urandom); iso = 12'($urandom & $urandom & $urandom);
            tp = ($urandom_range(0, 9) < 6) ? UsbPidOut : ($urandom_range(0, 3) != 0) ? UsbPidSetup : UsbPidIn;
            dp = ($urandom_range(0, 9) == 0) ? UsbPidNak : ($urandom_range(0, 1) != 0) ? UsbPidData1 : UsbPidData0;
            ep = 4'($urandom_range(0, 13));
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 67) : $urandom_range(0, 16);
            txn(tp, ($urandom_range(0, 9) == 0) ? 7'h05 : DevAddr, ep, dp, n, $urandom_range(0, 9) != 0, 0);
            if ($urandom_range(0, 5) == 0) swtog(12'($urandom), 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
